// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the two-core shared-memory bus.
//                It holds the default widths, the arbiter state encoding and
//                the RAM write-enable polarity.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  // The RAM write enable is active-high.
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } bus_state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_arbiter
//  Description : Round-robin arbiter for two requesters. It has no pre-emption,
//                and it hands the bus directly to a waiting core when the
//                current holder releases it.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                req0, req1  - bus requests from core0 / core1
//                state       - registered arbiter state (IDLE/GNT0/GNT1)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_rr_arbiter
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output bus_state_t state
);

  bus_state_t state_q, state_d;
  // 0 = core0 was granted most recently, 1 = core1.
  logic       last_owner_q, last_owner_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // A tie goes to the core that did not own the bus last.
          state_d = last_owner_q ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0) state_d = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!req1) state_d = req0 ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == GNT0) last_owner_d = 1'b0;
    else if (state_d == GNT1) last_owner_d = 1'b1;
  end

  // After reset last_owner is 1, so core0 wins the first simultaneous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign state = state_q;

endmodule : bus_rr_arbiter
`default_nettype wire

// File: rtl/system_bus.sv
`default_nettype none
// ============================================================================
//  Module      : system_bus
//  Description : Shared-memory bus that connects two CPU cores to a single RAM
//                or GPIO memory. A round-robin arbiter chooses the owner. The
//                owner's address, data and rw are muxed onto the RAM port, and
//                RAM read data is returned only to the owner.
//  Ports       : clk, reset                     - clock, sync active-high reset
//                coreN_request/grant            - bus handshake per core
//                coreN_data_in/data_out         - write / read data per core
//                coreN_address, coreN_rw        - address, 1=write 0=read
//                RAM_address, RAM_data_in, rw   - RAM request port
//                RAM_data_out                   - RAM read data
//  Revision    : 1.0  initial release
// ============================================================================
module system_bus
  import bus_pkg::*;
#(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core0_request,
  output logic              core0_grant,
  input  logic [DATA_W-1:0] core0_data_in,
  output logic [DATA_W-1:0] core0_data_out,
  input  logic [ADDR_W-1:0] core0_address,
  input  logic              core0_rw,
  input  logic              core1_request,
  output logic              core1_grant,
  input  logic [DATA_W-1:0] core1_data_in,
  output logic [DATA_W-1:0] core1_data_out,
  input  logic [ADDR_W-1:0] core1_address,
  input  logic              core1_rw,
  output logic [ADDR_W-1:0] RAM_address,
  output logic [DATA_W-1:0] RAM_data_in,
  input  logic [DATA_W-1:0] RAM_data_out,
  output logic              rw
);

  bus_state_t state;

  bus_rr_arbiter u_arbiter (
    .clk   (clk),
    .reset (reset),
    .req0  (core0_request),
    .req1  (core1_request),
    .state (state)
  );

  assign core0_grant = (state == GNT0);
  assign core1_grant = (state == GNT1);

  // The write enable is qualified with the live request. An owner that drops
  // its request in its last grant cycle therefore never issues a write.
  always_comb begin
    RAM_address    = '0;
    RAM_data_in    = '0;
    rw             = ~RW_WRITE;
    core0_data_out = '0;
    core1_data_out = '0;
    unique case (state)
      GNT0: begin
        RAM_address    = core0_address;
        RAM_data_in    = core0_data_in;
        rw             = core0_rw & core0_request;
        core0_data_out = RAM_data_out;
      end
      GNT1: begin
        RAM_address    = core1_address;
        RAM_data_in    = core1_data_in;
        rw             = core1_rw & core1_request;
        core1_data_out = RAM_data_out;
      end
      default: ;
    endcase
  end

endmodule : system_bus
`default_nettype wire

// File: tb/tb_system_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_bus
//  Description : Directed, table-driven self-checking bench for system_bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_system_bus;

  logic       clk = 1'b0;
  logic       reset;
  logic       core0_request, core1_request;
  logic       core0_grant, core1_grant;
  logic [7:0] core0_data_in, core1_data_in, core0_data_out, core1_data_out;
  logic [8:0] core0_address, core1_address;
  logic       core0_rw, core1_rw;
  logic [8:0] RAM_address;
  logic [7:0] RAM_data_in, RAM_data_out;
  logic       rw;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  system_bus dut (
    .clk            (clk),
    .reset          (reset),
    .core0_request  (core0_request),
    .core0_grant    (core0_grant),
    .core0_data_in  (core0_data_in),
    .core0_data_out (core0_data_out),
    .core0_address  (core0_address),
    .core0_rw       (core0_rw),
    .core1_request  (core1_request),
    .core1_grant    (core1_grant),
    .core1_data_in  (core1_data_in),
    .core1_data_out (core1_data_out),
    .core1_address  (core1_address),
    .core1_rw       (core1_rw),
    .RAM_address    (RAM_address),
    .RAM_data_in    (RAM_data_in),
    .RAM_data_out   (RAM_data_out),
    .rw             (rw)
  );

  typedef struct {
    logic       rst;
    logic       q0, q1, rw0, rw1;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1, rd;
    logic       e_g0, e_g1;
    logic [8:0] e_addr;
    logic [7:0] e_din;
    logic       e_rw;
    logic [7:0] e_do0, e_do1;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    core0_request = v.q0;   core1_request = v.q1;
    core0_rw      = v.rw0;  core1_rw      = v.rw1;
    core0_address = v.a0;   core1_address = v.a1;
    core0_data_in = v.d0;   core1_data_in = v.d1;
    RAM_data_out  = v.rd;
  endtask

  initial begin
    //          rst q0 q1 rw0 rw1 a0      a1      d0     d1     rd   | g0 g1 addr    din    rw do0    do1
    vecs[0]  = '{1, 1, 1, 0, 0, 9'h005, 9'h000, 8'hA5, 8'h00, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[1]  = '{1, 1, 1, 0, 0, 9'h005, 9'h000, 8'hA5, 8'h00, 8'h00, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[2]  = '{0, 1, 0, 1, 0, 9'h005, 9'h000, 8'hA5, 8'h00, 8'h77, 1, 0, 9'h005, 8'hA5, 1, 8'h77, 8'h00};
    vecs[3]  = '{0, 0, 0, 1, 0, 9'h005, 9'h000, 8'hA5, 8'h00, 8'h77, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[4]  = '{1, 0, 0, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h11, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[5]  = '{0, 1, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h11, 1, 0, 9'h010, 8'h12, 0, 8'h11, 8'h00};
    vecs[6]  = '{0, 0, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h11, 0, 1, 9'h020, 8'h34, 0, 8'h00, 8'h11};
    vecs[7]  = '{0, 0, 0, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h11, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[8]  = '{0, 1, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h11, 1, 0, 9'h010, 8'h12, 0, 8'h11, 8'h00};
    vecs[9]  = '{0, 0, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h3C, 0, 1, 9'h020, 8'h34, 0, 8'h00, 8'h3C};
    vecs[10] = '{1, 0, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h3C, 0, 0, 9'h000, 8'h00, 0, 8'h00, 8'h00};
    vecs[11] = '{0, 0, 1, 0, 0, 9'h010, 9'h020, 8'h12, 8'h34, 8'h3C, 0, 1, 9'h020, 8'h34, 0, 8'h00, 8'h3C};
    vecs[12] = '{0, 0, 1, 0, 1, 9'h010, 9'h1FF, 8'h12, 8'h5A, 8'h66, 0, 1, 9'h1FF, 8'h5A, 1, 8'h00, 8'h66};
    vecs[13] = '{0, 1, 0, 1, 1, 9'h0AB, 9'h1FF, 8'hC3, 8'h5A, 8'h66, 1, 0, 9'h0AB, 8'hC3, 1, 8'h66, 8'h00};
    vecs[14] = '{0, 1, 1, 1, 1, 9'h0AB, 9'h1FF, 8'hC3, 8'h5A, 8'h66, 1, 0, 9'h0AB, 8'hC3, 1, 8'h66, 8'h00};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d grant0", i), {15'd0, core0_grant}, {15'd0, vecs[i].e_g0});
      check($sformatf("v%0d grant1", i), {15'd0, core1_grant}, {15'd0, vecs[i].e_g1});
      check($sformatf("v%0d ram_addr", i), {7'd0, RAM_address}, {7'd0, vecs[i].e_addr});
      check($sformatf("v%0d ram_din", i), {8'd0, RAM_data_in}, {8'd0, vecs[i].e_din});
      check($sformatf("v%0d rw", i), {15'd0, rw}, {15'd0, vecs[i].e_rw});
      check($sformatf("v%0d do0", i), {8'd0, core0_data_out}, {8'd0, vecs[i].e_do0});
      check($sformatf("v%0d do1", i), {8'd0, core1_data_out}, {8'd0, vecs[i].e_do1});
    end

    // Still in GNT0 with rw0=1: dropping req0 must kill the write immediately.
    @(negedge clk);
    core0_request = 1'b0;
    #1;
    check("drop grant0_still", {15'd0, core0_grant}, 16'd1);
    check("drop rw_killed", {15'd0, rw}, 16'd0);
    check("drop addr_held", {7'd0, RAM_address}, 16'h00AB);
    @(posedge clk);
    #1;
    check("drop handoff_g1", {15'd0, core1_grant}, 16'd1);
    check("drop handoff_g0", {15'd0, core0_grant}, 16'd0);

    // A one-cycle grant: the request falls just as the grant arrives.
    @(negedge clk);
    core1_request = 1'b0;
    @(posedge clk);
    #1;
    check("oneshot idle", {14'd0, core0_grant, core1_grant}, 16'd0);
    @(negedge clk);
    core0_request = 1'b1;
    core0_rw      = 1'b1;
    @(posedge clk);
    #1;
    core0_request = 1'b0;
    #1;
    check("oneshot grant", {15'd0, core0_grant}, 16'd1);
    check("oneshot no_write", {15'd0, rw}, 16'd0);
    @(posedge clk);
    #1;
    check("oneshot release", {14'd0, core0_grant, core1_grant}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_system_bus
`default_nettype wire
